// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder.
// A single-word backing-RAM port is used for line refills and for write-through stores.
module dcache_responder #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

  state_t                                  state_q, state_d;
  logic [LINES-1:0]                        valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]             tag_q, tag_d;
  logic [LINES-1:0][WORDS-1:0][31:0]       data_q, data_d;
  logic [OFFSET_W-1:0]                     cnt_q, cnt_d;
  logic [31:0]                             addr_q, addr_d;
  logic [3:0]                              wen_q, wen_d;
  logic [31:0]                             wdata_q, wdata_d;
  logic [31:0]                             rdata_q, rdata_d;
  logic [31:0]                             hit_q, hit_d;
  logic [31:0]                             miss_q, miss_d;

  // Fields of the latched request address.
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic                tag_hit;

  assign req_tag   = addr_q[31 -: TAG_W];
  assign req_idx   = addr_q[OFFSET_W+2 +: INDEX_W];
  assign req_word  = addr_q[2 +: OFFSET_W];
  assign tag_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Next-state, array updates and the combinational memory/CPU handshake outputs.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    mem_req   = 1'b0;
    mem_wen   = 4'b0;
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    cpu_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Flush takes priority; a request raised alongside it is dropped.
        if (flush) begin
          valid_d = '0;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          wen_d   = cpu_wen;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (wen_q == 4'b0) begin
          if (tag_hit) begin
            rdata_d = data_q[req_idx][req_word];
            hit_d   = sat_inc(hit_q);
            state_d = RESP;
          end else begin
            // Line is invalid while being refilled so an abort never leaves mixed data valid.
            miss_d           = sat_inc(miss_q);
            cnt_d            = '0;
            valid_d[req_idx] = 1'b0;
            state_d          = REFILL;
          end
        end else begin
          if (tag_hit) begin
            for (int b = 0; b < 4; b++)
              if (wen_q[b]) data_d[req_idx][req_word][8*b +: 8] = wdata_q[8*b +: 8];
            hit_d = sat_inc(hit_q);
          end else begin
            miss_d = sat_inc(miss_q);
          end
          state_d = WRITE;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, cnt_q, 2'b00};
        if (mem_ack) begin
          data_d[req_idx][cnt_q] = mem_rdata;
          cnt_d                  = cnt_q + 1'b1;
          if (&cnt_q) begin
            valid_d[req_idx] = 1'b1;
            tag_d[req_idx]   = req_tag;
            // The last word is not yet in the array, so forward it from the bus.
            rdata_d = (req_word == cnt_q) ? mem_rdata : data_q[req_idx][req_word];
            state_d = RESP;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_wen   = wen_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits, request latch and counters with async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Tag and data storage; contents are qualified by valid so no reset is needed.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a zero-wait-state backing RAM model.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_responder dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          ready_cnt = 0;
  bit          mem_init = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] log_addr [$];
  logic [3:0]  log_wen [$];
  logic [31:0] log_wdata [$];

  // Backing RAM: acks in the same cycle mem_req is seen, logs every transfer,
  // applies byte-enabled writes, and counts cpu_ready pulses.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[8'h10] = 32'h11; mem[8'h11] = 32'h22; mem[8'h12] = 32'h33; mem[8'h13] = 32'h44;
      mem[8'h50] = 32'h55; mem[8'h51] = 32'h66; mem[8'h52] = 32'h77; mem[8'h53] = 32'h88;
      mem_init = 1'b1;
    end
    if (cpu_ready) ready_cnt++;
    if (mem_req && resetn) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[9:2]];
      log_addr.push_back(mem_addr);
      log_wen.push_back(mem_wen);
      log_wdata.push_back(mem_wdata);
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end else begin
      mem_ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access; lat = edges from the request sample edge to the edge that samples cpu_ready.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a; cpu_wen = w; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_wen = 4'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) break;
      lat++;
    end
    lat++;
    chk("ready_seen", {31'b0, cpu_ready}, 32'd1);
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'b0, cpu_ready}, 32'd0);
  endtask

  // Expects a 4-word refill of the line containing base to appear at log position n0.
  task automatic chk_refill(input string tag, input int n0, input logic [31:0] base);
    chk({tag, "_txns"}, 32'(log_addr.size() - n0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (n0 + k < log_addr.size()) begin
        chk({tag, "_addr"}, log_addr[n0+k], base + 32'(4*k));
        chk({tag, "_wen"}, {28'b0, log_wen[n0+k]}, 32'd0);
      end
    end
  endtask

  initial begin
    int lat;
    int n0;
    int rc0;
    bit found;
    resetn = 1'b0; cpu_req = 1'b0; flush = 1'b0;
    cpu_wen = 4'b0; cpu_addr = 32'b0; cpu_wdata = 32'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    resetn = 1'b1;

    // Cold read miss.
    n0 = log_addr.size();
    access(32'h40, 4'b0, 32'b0, lat);
    chk_refill("cold", n0, 32'h40);
    chk("cold_rdata", cpu_rdata, 32'h11);
    chk("cold_miss", miss_cnt, 32'd1);
    chk("cold_hit", hit_cnt, 32'd0);

    // Read hit in the same line.
    n0 = log_addr.size();
    access(32'h48, 4'b0, 32'b0, lat);
    chk("hit_txns", 32'(log_addr.size() - n0), 32'd0);
    chk("hit_lat", 32'(lat), 32'd2);
    chk("hit_rdata", cpu_rdata, 32'h33);
    chk("hit_hit", hit_cnt, 32'd1);

    // Write hit: write-through with byte enables, line merged.
    n0 = log_addr.size();
    access(32'h48, 4'b0011, 32'hAAAA_BBBB, lat);
    chk("wr_txns", 32'(log_addr.size() - n0), 32'd1);
    chk("wr_addr", log_addr[n0], 32'h48);
    chk("wr_wen", {28'b0, log_wen[n0]}, 32'h3);
    chk("wr_wdata", log_wdata[n0], 32'hAAAA_BBBB);
    chk("wr_hit", hit_cnt, 32'd2);

    n0 = log_addr.size();
    access(32'h48, 4'b0, 32'b0, lat);
    chk("merge_rdata", cpu_rdata, 32'h0000_BBBB);
    chk("merge_hit", hit_cnt, 32'd3);
    chk("merge_txns", 32'(log_addr.size() - n0), 32'd0);

    // Conflict miss evicts the line, then the old line misses again.
    n0 = log_addr.size();
    access(32'h148, 4'b0, 32'b0, lat);
    chk_refill("evict", n0, 32'h140);
    chk("evict_rdata", cpu_rdata, 32'h77);
    chk("evict_miss", miss_cnt, 32'd2);

    n0 = log_addr.size();
    access(32'h48, 4'b0, 32'b0, lat);
    chk_refill("reload", n0, 32'h40);
    chk("reload_rdata", cpu_rdata, 32'h0000_BBBB);
    chk("reload_miss", miss_cnt, 32'd3);
    chk("reload_hit", hit_cnt, 32'd3);

    // Write miss: no allocate, address low bits cleared on the bus.
    n0 = log_addr.size();
    access(32'h20B, 4'b1111, 32'h1234_5678, lat);
    chk("wmiss_addr", log_addr[n0], 32'h208);
    chk("wmiss_miss", miss_cnt, 32'd4);
    n0 = log_addr.size();
    access(32'h208, 4'b0, 32'b0, lat);
    chk_refill("noalloc", n0, 32'h200);
    chk("noalloc_rdata", cpu_rdata, 32'h1234_5678);
    chk("noalloc_miss", miss_cnt, 32'd5);

    access(32'h48, 4'b0, 32'b0, lat);
    chk("prefl_hit", hit_cnt, 32'd4);

    // Flush with a simultaneous request: request dropped, then line misses.
    rc0 = ready_cnt;
    n0 = log_addr.size();
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h48; cpu_wen = 4'b0;
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush_txns", 32'(log_addr.size() - n0), 32'd0);
    chk("flush_ready", 32'(ready_cnt - rc0), 32'd0);
    chk("flush_miss", miss_cnt, 32'd5);
    access(32'h48, 4'b0, 32'b0, lat);
    chk_refill("postfl", n0, 32'h40);
    chk("postfl_miss", miss_cnt, 32'd6);
    chk("postfl_rdata", cpu_rdata, 32'h0000_BBBB);

    // Reset during the third refill word.
    rc0 = ready_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h140; cpu_wen = 4'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_addr == 32'h148) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reached", {31'b0, found}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wen", {28'b0, mem_wen}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    chk("abort_ready", {31'b0, cpu_ready}, 32'd0);
    chk("abort_rdata", cpu_rdata, 32'd0);
    chk("abort_hit", hit_cnt, 32'd0);
    chk("abort_miss", miss_cnt, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_ready", 32'(ready_cnt - rc0), 32'd0);
    n0 = log_addr.size();
    access(32'h140, 4'b0, 32'b0, lat);
    chk_refill("postrst", n0, 32'h140);
    chk("postrst_rdata", cpu_rdata, 32'h55);
    chk("postrst_miss", miss_cnt, 32'd1);
    chk("postrst_hit", hit_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
